// File: rtl/uart_alu_if_if.sv
// Bus between uart_alu_if and the uart RX/TX FIFOs.
// The master modport is the command processor; the slave modport is the FIFO side.
interface uart_alu_if_if #(
   parameter int DATA_W = 8
);
   logic              rx_empty;
   logic [DATA_W-1:0] r_data;
   logic              rd_uart;
   logic              tx_full;
   logic [DATA_W-1:0] w_data;
   logic              wr_uart;
   logic              done;

   modport master (
      input  rx_empty, r_data, tx_full,
      output rd_uart, w_data, wr_uart, done
   );

   modport slave (
      output rx_empty, r_data, tx_full,
      input  rd_uart, w_data, wr_uart, done
   );
endinterface

// File: rtl/uart_alu_if.sv
// Three-byte command processor: pops A, B and an opcode, then pushes the 8-bit ALU result.
// Define UART_ALU_FLAGS_EN to push a second byte {5'b0, err, carry, zero} after each result.
module uart_alu_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 6
) (
   input  logic          clk,
   input  logic          reset,
   uart_alu_if_if.master bus
);

   localparam logic [2:0] GET_A    = 3'd0;
   localparam logic [2:0] GET_B    = 3'd1;
   localparam logic [2:0] GET_OP   = 3'd2;
   localparam logic [2:0] CALC     = 3'd3;
   localparam logic [2:0] SEND_RES = 3'd4;
`ifdef UART_ALU_FLAGS_EN
   localparam logic [2:0] SEND_FLG = 3'd5;
`endif

   localparam logic [OP_W-1:0] OP_ADD = OP_W'(8'h20);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(8'h22);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(8'h24);
   localparam logic [OP_W-1:0] OP_OR  = OP_W'(8'h25);
   localparam logic [OP_W-1:0] OP_XOR = OP_W'(8'h26);
   localparam logic [OP_W-1:0] OP_NOR = OP_W'(8'h27);
   localparam logic [OP_W-1:0] OP_SRL = OP_W'(8'h02);
   localparam logic [OP_W-1:0] OP_SRA = OP_W'(8'h03);

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] a_q, b_q, w_data_q;
   logic [OP_W-1:0]   op_q;
   logic              done_q;
   logic              rd_pop, wr_push;
   logic [DATA_W-1:0] alu_res;

   always_comb begin
      state_d = state_q;
      rd_pop  = 1'b0;
      wr_push = 1'b0;
      case (state_q)
         GET_A: begin
            rd_pop = !bus.rx_empty;
            if (rd_pop) state_d = GET_B;
         end
         GET_B: begin
            rd_pop = !bus.rx_empty;
            if (rd_pop) state_d = GET_OP;
         end
         GET_OP: begin
            rd_pop = !bus.rx_empty;
            if (rd_pop) state_d = CALC;
         end
         CALC: state_d = SEND_RES;
         SEND_RES: begin
            wr_push = !bus.tx_full;
`ifdef UART_ALU_FLAGS_EN
            if (wr_push) state_d = SEND_FLG;
`else
            if (wr_push) state_d = GET_A;
`endif
         end
`ifdef UART_ALU_FLAGS_EN
         SEND_FLG: begin
            wr_push = !bus.tx_full;
            if (wr_push) state_d = GET_A;
         end
`endif
         default: state_d = GET_A;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (op_q)
         OP_ADD:  alu_res = a_q + b_q;
         OP_SUB:  alu_res = a_q - b_q;
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_NOR:  alu_res = ~(a_q | b_q);
         OP_SRL:  alu_res = a_q >> b_q[2:0];
         OP_SRA:  alu_res = DATA_W'($signed(a_q) >>> b_q[2:0]);
         default: alu_res = '0;
      endcase
   end

`ifdef UART_ALU_FLAGS_EN
   logic [DATA_W:0] alu_sum;
   logic            alu_carry, alu_err;
   logic            zero_q, carry_q, err_q;

   always_comb begin
      alu_sum   = {1'b0, a_q} + {1'b0, b_q};
      alu_carry = 1'b0;
      alu_err   = 1'b0;
      case (op_q)
         OP_ADD: alu_carry = alu_sum[DATA_W];
         OP_SUB: alu_carry = (a_q < b_q);
         OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA: alu_carry = 1'b0;
         default: alu_err = 1'b1;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= GET_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         w_data_q <= '0;
         done_q   <= 1'b0;
`ifdef UART_ALU_FLAGS_EN
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            GET_A:  if (rd_pop) a_q  <= bus.r_data;
            GET_B:  if (rd_pop) b_q  <= bus.r_data;
            GET_OP: if (rd_pop) op_q <= bus.r_data[OP_W-1:0];
            CALC: begin
               w_data_q <= alu_res;
`ifdef UART_ALU_FLAGS_EN
               zero_q   <= (alu_res == '0);
               carry_q  <= alu_carry;
               err_q    <= alu_err;
`endif
            end
            SEND_RES: begin
`ifdef UART_ALU_FLAGS_EN
               // Flags byte is loaded on the result push so SEND_FLG offers it immediately.
               if (wr_push) w_data_q <= {{(DATA_W-3){1'b0}}, err_q, carry_q, zero_q};
`else
               if (wr_push) done_q <= 1'b1;
`endif
            end
`ifdef UART_ALU_FLAGS_EN
            SEND_FLG: if (wr_push) done_q <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Strobes are gated by reset so no byte is popped or pushed while the FSM is being cleared.
   assign bus.rd_uart = rd_pop && !reset;
   assign bus.wr_uart = wr_push && !reset;
   assign bus.w_data  = w_data_q;
   assign bus.done    = done_q;

endmodule
